// File: rtl/dispatcher.sv
// Block dispatcher: splits a kernel of thread_count threads into blocks of
// THREADS_PER_BLOCK threads and hands them out to NUM_CORES core schedulers.
// Every output is a flop; a core is handed a new block on the same edge that
// returns it to FREE, so core_start follows the core_reset pulse directly.
module dispatcher #(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             thread_count,
  input  logic [NUM_CORES-1:0]   core_done,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [NUM_CORES-1:0]   core_reset,
  output logic [NUM_CORES*8-1:0] core_block_id_flat,
  output logic [NUM_CORES*8-1:0] core_thread_count_flat,
  output logic                   done
);

  localparam int unsigned LogTpb = $clog2(THREADS_PER_BLOCK);
  localparam logic [8:0]  TpbM1  = 9'(THREADS_PER_BLOCK - 1);
  localparam logic [15:0] Tpb16  = 16'(THREADS_PER_BLOCK);
  localparam logic [7:0]  Tpb8   = 8'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    StIdle,
    StResetCores,
    StRun,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    CoreFree,
    CoreBusy,
    CoreRecycle
  } core_state_e;

  state_e                 state_q, state_d;
  core_state_e            core_state_q [NUM_CORES];
  core_state_e            core_state_d [NUM_CORES];
  logic [7:0]             thread_count_q, thread_count_d;
  logic [8:0]             total_blocks_q, total_blocks_d;
  logic [7:0]             blocks_dispatched_q, blocks_dispatched_d;
  logic [7:0]             blocks_done_q, blocks_done_d;
  logic [NUM_CORES-1:0]   core_start_q, core_start_d;
  logic [NUM_CORES-1:0]   core_reset_q, core_reset_d;
  logic [NUM_CORES*8-1:0] block_id_q, block_id_d;
  logic [NUM_CORES*8-1:0] block_cnt_q, block_cnt_d;
  logic                   done_q, done_d;

  logic [NUM_CORES-1:0]   eligible;
  logic [7:0]             done_inc;
  logic                   assigned;
  logic [15:0]            block_base;
  logic [15:0]            remaining;
  logic [7:0]             blk_cnt;

  // Size of the block about to be dispatched; only the last block can be short.
  assign block_base = 16'(blocks_dispatched_q) * Tpb16;
  assign remaining  = 16'(thread_count_q) - block_base;
  assign blk_cnt    = (remaining >= Tpb16) ? Tpb8 : remaining[7:0];

  // Next-state for the top FSM, per-core FSMs, counters and registered outputs.
  always_comb begin
    state_d             = state_q;
    core_state_d        = core_state_q;
    thread_count_d      = thread_count_q;
    total_blocks_d      = total_blocks_q;
    blocks_dispatched_d = blocks_dispatched_q;
    blocks_done_d       = blocks_done_q;
    core_start_d        = '0;
    core_reset_d        = '0;
    block_id_d          = block_id_q;
    block_cnt_d         = block_cnt_q;
    eligible            = '0;
    done_inc            = '0;
    assigned            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          thread_count_d      = thread_count;
          total_blocks_d      = ({1'b0, thread_count} + TpbM1) >> LogTpb;
          blocks_dispatched_d = '0;
          blocks_done_d       = '0;
          core_reset_d        = '1;
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_state_d[i] = CoreFree;
          end
          state_d = StResetCores;
        end
      end
      StResetCores: begin
        // All cores come out of the reset pulse FREE, so all may take a block.
        eligible = '1;
        state_d  = StRun;
      end
      StRun: begin
        if (9'(blocks_done_q) == total_blocks_q) begin
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_state_d[i] = CoreFree;
          end
          state_d = StDone;
        end else begin
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            unique case (core_state_q[i])
              CoreBusy: begin
                if (core_done[i]) begin
                  core_state_d[i] = CoreRecycle;
                  core_reset_d[i] = 1'b1;
                  done_inc        = done_inc + 8'd1;
                end
              end
              CoreRecycle: begin
                core_state_d[i] = CoreFree;
                eligible[i]     = 1'b1;
              end
              CoreFree: begin
                eligible[i] = 1'b1;
              end
              default: begin
                core_state_d[i] = CoreFree;
              end
            endcase
          end
          blocks_done_d = blocks_done_q + done_inc;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Hand the next block to the lowest-indexed eligible core, one per cycle.
    if (9'(blocks_dispatched_q) < total_blocks_q) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!assigned && eligible[i]) begin
          assigned                = 1'b1;
          core_state_d[i]         = CoreBusy;
          core_start_d[i]         = 1'b1;
          block_id_d[i*8 +: 8]    = blocks_dispatched_q;
          block_cnt_d[i*8 +: 8]   = blk_cnt;
        end
      end
      if (assigned) begin
        blocks_dispatched_d = blocks_dispatched_q + 8'd1;
      end
    end

    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        core_state_q[i] <= CoreFree;
      end
      thread_count_q      <= '0;
      total_blocks_q      <= '0;
      blocks_dispatched_q <= '0;
      blocks_done_q       <= '0;
      core_start_q        <= '0;
      core_reset_q        <= '0;
      block_id_q          <= '0;
      block_cnt_q         <= '0;
      done_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      core_state_q        <= core_state_d;
      thread_count_q      <= thread_count_d;
      total_blocks_q      <= total_blocks_d;
      blocks_dispatched_q <= blocks_dispatched_d;
      blocks_done_q       <= blocks_done_d;
      core_start_q        <= core_start_d;
      core_reset_q        <= core_reset_d;
      block_id_q          <= block_id_d;
      block_cnt_q         <= block_cnt_d;
      done_q              <= done_d;
    end
  end

  assign core_start             = core_start_q;
  assign core_reset             = core_reset_q;
  assign core_block_id_flat     = block_id_q;
  assign core_thread_count_flat = block_cnt_q;
  assign done                   = done_q;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: hand-written multi-cycle sequences followed by
// a table of kernels run against a simple core-scheduler responder.
module tb_dispatcher;

  localparam int unsigned NC  = 2;
  localparam int unsigned TPB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    thread_count;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_start;
  logic [NC-1:0] core_reset;
  logic [NC*8-1:0] bid;
  logic [NC*8-1:0] tcnt;
  logic          done;

  always #5 clk = ~clk;

  dispatcher #(
    .NUM_CORES         (NC),
    .THREADS_PER_BLOCK (TPB)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .thread_count           (thread_count),
    .core_done              (core_done),
    .core_start             (core_start),
    .core_reset             (core_reset),
    .core_block_id_flat     (bid),
    .core_thread_count_flat (tcnt),
    .done                   (done)
  );

  typedef struct {
    logic [7:0] tc;
    int         blocks;
    int         last_cnt;
  } vec_t;

  vec_t vecs [9];

  int n_checks = 0;
  int n_pass   = 0;

  bit            auto_resp;
  int            busy_cnt [NC];
  logic [NC-1:0] done_lvl;
  int            resp_done;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // One clock; sample #1 after the edge, then update the core responder.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      for (int i = 0; i < NC; i++) begin
        if (core_reset[i]) done_lvl[i] = 1'b0;
        if (core_start[i]) begin
          busy_cnt[i] = 1 + i + (int'(bid[i*8 +: 8]) % 3);
        end else if (busy_cnt[i] > 0) begin
          busy_cnt[i]--;
          if (busy_cnt[i] == 0) begin
            done_lvl[i] = 1'b1;
            resp_done++;
          end
        end
      end
      core_done = done_lvl;
    end
  endtask

  task automatic run_kernel(input vec_t v);
    int exp_id;
    int cnt_exp;
    bit seen_done;
    auto_resp = 1'b1;
    done_lvl  = '0;
    core_done = '0;
    resp_done = 0;
    for (int i = 0; i < NC; i++) busy_cnt[i] = 0;
    exp_id       = 0;
    seen_done    = 1'b0;
    thread_count = v.tc;
    start        = 1'b1;
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      step();
      start = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          cnt_exp = (exp_id == v.blocks - 1) ? v.last_cnt : TPB;
          check($sformatf("tc%0d block id", v.tc), int'(bid[i*8 +: 8]), exp_id);
          check($sformatf("tc%0d block cnt id%0d", v.tc, exp_id), int'(tcnt[i*8 +: 8]), cnt_exp);
          exp_id++;
        end
      end
      if (done) seen_done = 1'b1;
    end
    check($sformatf("tc%0d done reached", v.tc), int'(seen_done), 1);
    check($sformatf("tc%0d blocks started", v.tc), exp_id, v.blocks);
    check($sformatf("tc%0d core_done count at done", v.tc), resp_done, v.blocks);
    step();
    check($sformatf("tc%0d done cleared", v.tc), int'(done), 0);
    auto_resp = 1'b0;
    core_done = '0;
  endtask

  initial begin
    vecs[0] = '{tc: 8'd4,   blocks: 1,  last_cnt: 4};
    vecs[1] = '{tc: 8'd8,   blocks: 2,  last_cnt: 4};
    vecs[2] = '{tc: 8'd10,  blocks: 3,  last_cnt: 2};
    vecs[3] = '{tc: 8'd1,   blocks: 1,  last_cnt: 1};
    vecs[4] = '{tc: 8'd5,   blocks: 2,  last_cnt: 1};
    vecs[5] = '{tc: 8'd7,   blocks: 2,  last_cnt: 3};
    vecs[6] = '{tc: 8'd0,   blocks: 0,  last_cnt: 0};
    vecs[7] = '{tc: 8'd255, blocks: 64, last_cnt: 3};
    vecs[8] = '{tc: 8'd128, blocks: 32, last_cnt: 4};

    auto_resp    = 1'b0;
    reset        = 1'b1;
    start        = 1'b0;
    thread_count = '0;
    core_done    = '0;
    step();
    step();
    check("reset done", int'(done), 0);
    check("reset core_start", int'(core_start), 0);
    check("reset core_reset", int'(core_reset), 0);
    check("reset block ids", int'(bid), 0);
    check("reset block cnts", int'(tcnt), 0);

    // Two blocks of four; start accepted on the first cycle out of reset.
    reset        = 1'b0;
    start        = 1'b1;
    thread_count = 8'd8;
    step();
    check("tc8 core_reset pulse", int'(core_reset), 3);
    check("tc8 no early start", int'(core_start), 0);
    step();
    check("tc8 core0 start", int'(core_start), 1);
    check("tc8 reset pulse one cycle", int'(core_reset), 0);
    check("tc8 core0 id", int'(bid[7:0]), 0);
    check("tc8 core0 cnt", int'(tcnt[7:0]), 4);
    step();
    check("tc8 core1 start", int'(core_start), 2);
    check("tc8 core1 id", int'(bid[15:8]), 1);
    check("tc8 core1 cnt", int'(tcnt[15:8]), 4);
    check("tc8 core0 id held", int'(bid[7:0]), 0);
    core_done = 2'b11;
    step();
    check("tc8 both recycle", int'(core_reset), 3);
    check("tc8 not done yet", int'(done), 0);
    core_done = 2'b00;
    step();
    check("tc8 done", int'(done), 1);
    step();
    check("tc8 done held with start high", int'(done), 1);
    check("tc8 no relaunch", int'(core_reset), 0);
    start = 1'b0;
    step();
    check("tc8 done clears in idle", int'(done), 0);

    // Three blocks: the short last block goes to the first core to recycle.
    start        = 1'b1;
    thread_count = 8'd10;
    step();
    step();
    step();
    start     = 1'b0;
    core_done = 2'b10;
    step();
    check("tc10 core1 recycle", int'(core_reset), 2);
    check("tc10 no start during recycle", int'(core_start), 0);
    core_done = 2'b00;
    step();
    check("tc10 core1 reassigned", int'(core_start), 2);
    check("tc10 core1 id2", int'(bid[15:8]), 2);
    check("tc10 core1 cnt2", int'(tcnt[15:8]), 2);
    core_done = 2'b01;
    step();
    check("tc10 core0 recycle", int'(core_reset), 1);
    core_done = 2'b10;
    step();
    check("tc10 core1 recycle again", int'(core_reset), 2);
    check("tc10 not done before last count", int'(done), 0);
    core_done = 2'b00;
    step();
    check("tc10 done", int'(done), 1);
    step();
    check("tc10 done cleared", int'(done), 0);

    // Four blocks: simultaneous completion, reuse, then reset mid-run.
    start        = 1'b1;
    thread_count = 8'd16;
    step();
    step();
    step();
    start     = 1'b0;
    core_done = 2'b11;
    step();
    check("tc16 dual recycle", int'(core_reset), 3);
    core_done = 2'b00;
    step();
    check("tc16 core0 reuse", int'(core_start), 1);
    check("tc16 core0 id2", int'(bid[7:0]), 2);
    step();
    check("tc16 core1 reuse", int'(core_start), 2);
    check("tc16 core1 id3", int'(bid[15:8]), 3);
    reset = 1'b1;
    step();
    check("midrun reset core_start", int'(core_start), 0);
    check("midrun reset core_reset", int'(core_reset), 0);
    check("midrun reset ids", int'(bid), 0);
    check("midrun reset cnts", int'(tcnt), 0);
    check("midrun reset done", int'(done), 0);
    reset = 1'b0;

    for (int k = 0; k < 9; k++) begin
      run_kernel(vecs[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
